mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters:
  - the multicycle CPU control/datapath (fetch, LWI, SWI accesses);
  - a host program loader/debug port.
- Round-robin arbitration with a bounded host burst lock.
- Produces a CPU stall flag that the control state machine uses to hold its state (gates its start).
- Sits between the datapath's IorD-muxed address/write path and the memory array.

---
 rtl/mem_port_arbiter.sv | 68 ++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory between the CPU and a host port,
// with a bounded host burst lock and a CPU stall flag.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic                  cpu_stall,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic                  host_lock,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_HOST} state_t;
    state_t state, state_nx, arb_pick;
    logic last_owner, last_owner_nx, arb_last, hold;
    logic [3:0] lock_cnt, lock_cnt_nx;
    assign cpu_gnt = (state == OWN_CPU) && cpu_req;
    assign host_gnt = (state == OWN_HOST) && host_req;
    assign cpu_stall = cpu_req && !cpu_gnt;
    assign mem_en = cpu_gnt || host_gnt;
    assign mem_we = (cpu_gnt && cpu_we) || (host_gnt && host_we);
    assign mem_addr = cpu_gnt ? cpu_addr : host_gnt ? host_addr : '0;
    assign mem_wdata = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
    assign rdata = mem_rdata;
    // A transfer issued this cycle counts as the latest owner for the same-cycle re-arbitration.
    always_comb begin
        arb_last = cpu_gnt ? 1'b0 : host_gnt ? 1'b1 : last_owner;
        arb_pick = (cpu_req && host_req) ? (arb_last ? OWN_CPU : OWN_HOST)
                 : cpu_req ? OWN_CPU : host_req ? OWN_HOST : IDLE;
        hold = host_gnt && host_lock && (!cpu_req || lock_cnt < 4'(MAX_LOCK - 1));
        state_nx = hold ? OWN_HOST : arb_pick;
        last_owner_nx = arb_last;
        lock_cnt_nx = hold ? lock_cnt + {3'b000, lock_cnt != 4'hf} : 4'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last_owner <= 1'b1;
            lock_cnt <= 4'd0;
            cpu_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            state <= state_nx;
            last_owner <= last_owner_nx;
            lock_cnt <= lock_cnt_nx;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            host_rvalid <= host_gnt && !host_we;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized checks of mem_port_arbiter against an owner/run-length model.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int ML = 4;
    logic clk = 0;
    logic reset = 1;
    logic cpu_req = 0, cpu_we = 0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic cpu_gnt, cpu_rvalid, cpu_stall;
    logic host_req = 0, host_we = 0, host_lock = 0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic host_gnt, host_rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] seed(logic [AW-1:0] a);
        return (a == 8'h05) ? 16'h1234 : {~a, a};
    endfunction

    // Memory array: unwritten words read as seed(addr).
    bit [DW-1:0] tmem [256];
    bit tv [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                tmem[mem_addr] <= mem_wdata;
                tv[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= tv[mem_addr] ? tmem[mem_addr] : seed(mem_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Model: who owns the bus (0 none, 1 cpu, 2 host), who last transferred, and length of the current locked host run.
    int m_own = 0, m_last = 2, m_run = 0;
    bit m_pc = 0, m_ph = 0;
    logic [DW-1:0] m_pd = '0;
    bit [DW-1:0] mm [256];
    bit mv [256];
    initial begin : model
        bit ec, eh, hold, n_pc, n_ph;
        int lo, pick, n_own, n_run;
        logic [AW-1:0] ra;
        logic [DW-1:0] n_pd;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_own = 0; m_last = 2; m_run = 0; m_pc = 0; m_ph = 0;
                chk("rst_outputs", {cpu_gnt, host_gnt, mem_en, mem_we, cpu_rvalid, host_rvalid}, 0);
                chk("rst_bus", {mem_addr, mem_wdata}, 0);
            end else begin
                ec = (m_own == 1) && cpu_req;
                eh = (m_own == 2) && host_req;
                chk("cpu_gnt", cpu_gnt, ec);
                chk("host_gnt", host_gnt, eh);
                chk("cpu_stall", cpu_stall, cpu_req && !ec);
                chk("mem_en", mem_en, ec || eh);
                chk("mem_we", mem_we, (ec && cpu_we) || (eh && host_we));
                chk("mem_addr", mem_addr, ec ? cpu_addr : eh ? host_addr : 8'h00);
                chk("mem_wdata", mem_wdata, ec ? cpu_wdata : eh ? host_wdata : 16'h0000);
                chk("cpu_rvalid", cpu_rvalid, m_pc);
                chk("host_rvalid", host_rvalid, m_ph);
                if (m_pc || m_ph) chk("rdata", rdata, m_pd);
                lo = ec ? 1 : eh ? 2 : m_last;
                pick = (cpu_req && host_req) ? 3 - lo : cpu_req ? 1 : host_req ? 2 : 0;
                hold = eh && host_lock && (!cpu_req || m_run + 1 < ML);
                n_own = hold ? 2 : pick;
                n_run = hold ? m_run + 1 : 0;
                n_pc = ec && !cpu_we;
                n_ph = eh && !host_we;
                ra = ec ? cpu_addr : host_addr;
                n_pd = mv[ra] ? mm[ra] : seed(ra);
                @(posedge clk);
                if (!reset) begin
                    if (ec && cpu_we) begin mm[cpu_addr] = cpu_wdata; mv[cpu_addr] = 1; end
                    if (eh && host_we) begin mm[host_addr] = host_wdata; mv[host_addr] = 1; end
                    m_own = n_own; m_last = lo; m_run = n_run;
                    m_pc = n_pc; m_ph = n_ph; m_pd = n_pd;
                end
            end
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive();
        reset = 1; cpu_req = 0; host_req = 0; host_lock = 0;
        drive();
        drive();
        reset = 0;
    endtask

    initial begin : stim
        bit gc, gh, got;
        int n, pc;
        @(negedge clk);
        chk("reset_state", {cpu_gnt, host_gnt, mem_en, mem_we, cpu_rvalid, host_rvalid, mem_addr, mem_wdata}, 0);
        // CPU read, first grant after the idle bubble
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
        @(negedge clk);
        chk("t1_c0_stall", cpu_stall, 1);
        chk("t1_c0_gnt", cpu_gnt, 0);
        drive();
        @(negedge clk);
        chk("t1_c1_gnt", cpu_gnt, 1);
        chk("t1_c1_stall", cpu_stall, 0);
        drive();
        cpu_req = 0;
        @(negedge clk);
        chk("t1_c2_rvalid", cpu_rvalid, 1);
        chk("t1_c2_rdata", rdata, 16'h1234);
        chk("t1_c2_stall", cpu_stall, 0);
        // Both requesting continuously: strict alternation
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 16'hBEEF;
        @(negedge clk);
        chk("t2_c0_gnt", {cpu_gnt, host_gnt}, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            drive();
            @(negedge clk);
            chk("t2_gnt", {cpu_gnt, host_gnt}, i[0] ? 2'b10 : 2'b01);
            chk("t2_we", mem_we, !i[0]);
        end
        chk("t2_c4_rvalid", cpu_rvalid, 1);
        chk("t2_c4_rdata", rdata, 16'hBEEF);
        drive();
        cpu_req = 0; host_req = 0;
        // Host lock with CPU pending: exactly MAX_LOCK host transfers
        do_reset();
        host_req = 1; host_lock = 1; host_we = 0; host_addr = 8'h30;
        drive();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h31;
        for (int i = 0; i < ML; i++) begin
            @(negedge clk);
            chk("t3_host_gnt", host_gnt, 1);
            chk("t3_stall", cpu_stall, 1);
            drive();
        end
        @(negedge clk);
        chk("t3_cpu_gnt", {cpu_gnt, host_gnt}, 2'b10);
        drive();
        cpu_req = 0; host_req = 0; host_lock = 0;
        // Host lock with no CPU request: unbounded run, then release on cpu_req
        do_reset();
        host_req = 1; host_lock = 1; host_we = 1; host_addr = 8'h40; host_wdata = 16'h5A5A;
        drive();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("t4_host_run", host_gnt, 1);
            drive();
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h41;
        n = 0; got = 0;
        for (int i = 0; i < 2 * ML && !got; i++) begin
            @(negedge clk);
            if (cpu_gnt) got = 1;
            else if (host_gnt) n++;
            if (!got) drive();
        end
        chk("t4_cpu_granted", got, 1);
        chk("t4_host_before_cpu_within_lock", n <= ML, 1);
        drive();
        cpu_req = 0; host_req = 0; host_lock = 0;
        // Asynchronous reset one cycle after a CPU read grant
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
        drive();
        @(negedge clk);
        chk("t5_gnt", cpu_gnt, 1);
        drive();
        reset = 1; cpu_req = 0;
        #1;
        chk("t5_async_rvalid", cpu_rvalid, 0);
        chk("t5_async_outputs", {cpu_gnt, host_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, host_rvalid}, 0);
        @(negedge clk);
        chk("t5_rvalid_dropped", cpu_rvalid, 0);
        drive();
        drive();
        reset = 0; cpu_req = 1;
        @(negedge clk);
        chk("t5_post_c0", cpu_gnt, 0);
        drive();
        @(negedge clk);
        chk("t5_post_c1", cpu_gnt, 1);
        drive();
        cpu_req = 0;
        // CPU write followed by host read of the same word
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 16'h00FF;
        host_req = 1; host_we = 0; host_addr = 8'h20;
        drive();
        @(negedge clk);
        chk("t6_cpu_write", {cpu_gnt, mem_we}, 2'b11);
        drive();
        cpu_req = 0;
        @(negedge clk);
        chk("t6_host_gnt", host_gnt, 1);
        chk("t6_no_cpu_rvalid", cpu_rvalid, 0);
        drive();
        host_req = 0;
        @(negedge clk);
        chk("t6_host_rvalid", host_rvalid, 1);
        chk("t6_rdata", rdata, 16'h00FF);
        chk("t6_no_cpu_rvalid2", cpu_rvalid, 0);
        // Randomized protocol-compliant traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gc = cpu_gnt; gh = host_gnt;
            drive();
            pc = ((c % 600) < 300) ? 70 : 8;
            if (gc || !cpu_req) begin
                cpu_req = ($urandom_range(99) < pc);
                cpu_we = 1'($urandom_range(1));
                cpu_addr = 8'($urandom_range(15));
                cpu_wdata = 16'($urandom);
            end
            if (gh || !host_req) begin
                host_req = ($urandom_range(99) < 65);
                host_we = 1'($urandom_range(1));
                host_addr = 8'($urandom_range(15));
                host_wdata = 16'($urandom);
            end
            host_lock = ($urandom_range(99) < 60);
        end
        drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
